bufram_line_ctrl: RTL and testbench
===================================

BUFRAM_LINE_CTRL -- requirements
Module: bufram_line_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, giving log2 of words per buffered line (8 x 32-bit words).
REQ-002 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port acc_req  in  1  read request; held high until acc_ack.
REQ-005 SHALL have port acc_adr  in  32  byte address; word index is acc_adr[ADDR_WIDTH+1:2], tag is acc_adr[31:ADDR_WIDTH+2].
REQ-006 SHALL have port acc_dat_o  out  32  read data, valid while acc_ack is high.
REQ-007 SHALL have port acc_ack  out  1  one-cycle completion pulse.
REQ-008 SHALL have port mem_req  out  1  line-fill request to the memory side.
REQ-009 SHALL have port mem_adr  out  32  line-aligned fill address (bits ADDR_WIDTH+1:0 zero).
REQ-010 SHALL have port mem_gnt  in  1  one-cycle acceptance of mem_req.
REQ-011 SHALL have port mem_dv  in  1  fill beat valid.
REQ-012 SHALL have port mem_dat  in  32  fill beat data.
REQ-013 SHALL have port snoop_valid  in  1  external write notification.
REQ-014 SHALL have port snoop_adr  in  32  byte address of the external write.
REQ-015 SHALL have port buf_addr  out  ADDR_WIDTH  buffer RAM word address.
REQ-016 SHALL have port buf_we  out  4  buffer RAM byte write enables.
REQ-017 SHALL have port buf_di  out  32  buffer RAM write data.
REQ-018 SHALL have port buf_do  in  32  buffer RAM read data, one-cycle synchronous read latency.

Function
REQ-019 SHALL keep one line tag register and one valid bit; hit = valid and stored tag equals the acc_adr tag.
REQ-020 SHALL implement states IDLE, FILL_REQ, FILL, READ, RESP.
REQ-021 IDLE: acc_req and hit -> drive buf_addr = acc word index and go to RESP; acc_req and miss -> latch tag and word index and go to FILL_REQ; otherwise stay.
REQ-022 FILL_REQ: assert mem_req and mem_adr = {tag, zeros}; mem_req stays high until mem_gnt; on mem_gnt go to FILL with beat counter 0.
REQ-023 FILL: each mem_dv writes mem_dat to buf_addr = beat counter with buf_we = 4'hF; counter increments per beat; mem_dv gaps are allowed; mem_dv outside FILL is ignored.
REQ-024 On the 2^ADDR_WIDTH-th beat SHALL load the tag, set valid (unless REQ-030 applies), and go to READ.
REQ-025 READ: drive buf_addr = latched word index and go to RESP.
REQ-026 RESP: acc_ack = 1 and acc_dat_o = buf_do for exactly one cycle, then go to IDLE.
REQ-027 Hit latency SHALL be 1 cycle (acc_req seen in cycle N, acc_ack in N+1); miss latency SHALL be gnt cycle + all beats + 2 cycles.
REQ-028 buf_we SHALL be 0 in every state except FILL beats; acc_ack and mem_req SHALL never be high outside RESP and FILL_REQ respectively.
REQ-029 Beat counter SHALL be ADDR_WIDTH+1 bits wide so that completion is detected without wrap ambiguity.
REQ-030 Snoop, when enabled: a snoop_valid whose tag matches the stored tag clears valid the next cycle; a snoop_valid during FILL_REQ/FILL matching the fill tag marks the fill stale, so completion leaves valid = 0 while the pending access is still acked with the filled data.
REQ-031 Snoop and a hit in the same IDLE cycle: the access SHALL complete as a hit, and valid SHALL be cleared afterwards.

Reset
REQ-032 rst SHALL force state IDLE, valid 0, beat counter 0, stale 0, and acc_ack, mem_req, buf_we, mem_adr, acc_dat_o to 0.
REQ-033 rst during FILL_REQ or FILL SHALL abandon the fill with no ack and valid 0; the memory side shares rst.

Configuration
REQ-034 Macro BUFRAM_LINE_CTRL_SNOOP_EN: when defined, REQ-030/031 are active; when undefined, snoop_valid and snoop_adr are ignored, the ports remain, and valid is cleared only by reset.

Verification
REQ-035 Reset, then a read at 0x100 -> mem_req with mem_adr 0x100; gnt; 8 beats 0xA0..0xA7; acc_ack with acc_dat_o 0xA0.
REQ-036 Read at 0x11C following REQ-035 -> no mem_req; acc_ack one cycle later with 0xA7.
REQ-037 Read at 0x120 after the line is valid -> new fill at 0x120; a subsequent read at 0x104 misses again.
REQ-038 With SNOOP_EN, snoop 0x108 mid-fill of 0x100 -> acc_ack with correct data; the next read at 0x100 refetches; without SNOOP_EN -> the next read hits.
REQ-039 Fill with mem_dv gaps of 0-3 cycles -> exactly 8 buffer writes at addresses 0-7; a stray mem_dv in IDLE produces no write.
REQ-040 rst asserted on the 4th beat -> no ack; valid 0; a read at 0x100 after reset issues a new mem_req.

Source files
------------

// File: rtl/bufram_line_ctrl.sv
// bufram_line_ctrl: single-line read buffer controller with line fill and optional snoop invalidation.
// Snoop invalidation is built only when BUFRAM_LINE_CTRL_SNOOP_EN is defined.
module bufram_line_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_req,
  input  logic [31:0]           acc_adr,
  output logic [31:0]           acc_dat_o,
  output logic                  acc_ack,
  output logic                  mem_req,
  output logic [31:0]           mem_adr,
  input  logic                  mem_gnt,
  input  logic                  mem_dv,
  input  logic [31:0]           mem_dat,
  input  logic                  snoop_valid,
  input  logic [31:0]           snoop_adr,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [3:0]            buf_we,
  output logic [31:0]           buf_di,
  input  logic [31:0]           buf_do
);
  localparam int TW = 30 - ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL, READ, RESP} state_t;
  state_t state;
  logic [TW-1:0] line_tag, fill_tag, acc_tag;
  logic [ADDR_WIDTH-1:0] word_idx, acc_idx;
  logic [ADDR_WIDTH:0] cnt, cnt_nxt;
  logic valid, stale, hit, snp_line, snp_fill, unused_bits;
  assign acc_tag = acc_adr[31:ADDR_WIDTH+2];
  assign acc_idx = acc_adr[ADDR_WIDTH+1:2];
  assign hit = valid && line_tag == acc_tag;
  assign cnt_nxt = cnt + 1'b1;
`ifdef BUFRAM_LINE_CTRL_SNOOP_EN
  assign snp_line = snoop_valid && snoop_adr[31:ADDR_WIDTH+2] == line_tag;
  assign snp_fill = snoop_valid && (state == FILL_REQ || state == FILL) && snoop_adr[31:ADDR_WIDTH+2] == fill_tag;
  assign unused_bits = ^{acc_adr[1:0], snoop_adr[ADDR_WIDTH+1:0]};
`else
  assign snp_line = 1'b0;
  assign snp_fill = 1'b0;
  assign unused_bits = ^{acc_adr[1:0], snoop_valid, snoop_adr};
`endif
  // Address is combinational so a hit reads the RAM in the request cycle.
  assign buf_addr = state == FILL ? cnt[ADDR_WIDTH-1:0] : state == READ ? word_idx : acc_idx;
  assign buf_we = (state == FILL && mem_dv) ? 4'hF : 4'h0;
  assign buf_di = mem_dat;
  assign acc_dat_o = acc_ack ? buf_do : 32'h0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      stale <= 1'b0;
      cnt <= '0;
      acc_ack <= 1'b0;
      mem_req <= 1'b0;
      mem_adr <= 32'h0;
      line_tag <= '0;
      fill_tag <= '0;
      word_idx <= '0;
    end else begin
      acc_ack <= 1'b0;
      if (snp_line) valid <= 1'b0;
      case (state)
        IDLE: if (acc_req) begin
          if (hit) begin
            state <= RESP;
            acc_ack <= 1'b1;
          end else begin
            fill_tag <= acc_tag;
            word_idx <= acc_idx;
            stale <= 1'b0;
            mem_req <= 1'b1;
            mem_adr <= {acc_tag, {(ADDR_WIDTH+2){1'b0}}};
            state <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (snp_fill) stale <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_adr <= 32'h0;
            cnt <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (snp_fill) stale <= 1'b1;
          if (mem_dv) begin
            cnt <= cnt_nxt;
            if (cnt_nxt[ADDR_WIDTH]) begin
              line_tag <= fill_tag;
              valid <= !(stale || snp_fill);
              state <= READ;
            end
          end
        end
        READ: begin
          state <= RESP;
          acc_ack <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bufram_line_ctrl.sv
// tb_bufram_line_ctrl: directed plus randomized reads checked against a line-buffer model.
module tb_bufram_line_ctrl;
`ifdef BUFRAM_LINE_CTRL_SNOOP_EN
  localparam bit SNP = 1'b1;
`else
  localparam bit SNP = 1'b0;
`endif
  logic clk = 0, rst = 1, acc_req = 0, acc_ack, mem_req, mem_gnt = 0, mem_dv = 0, snoop_valid = 0;
  logic [31:0] acc_adr = 0, acc_dat_o, mem_adr, mem_dat = 0, snoop_adr = 0, buf_di, buf_do;
  logic [2:0] buf_addr;
  logic [3:0] buf_we;
  logic [31:0] ram [8];
  int wr_cnt[8] = '{default: 0};
  int wr_tot = 0;
  int passed = 0, total = 0;
  bit mdl_valid = 0;
  logic [26:0] mdl_tag = 0;
  logic [31:0] mdl_data [8];
  bufram_line_ctrl dut (
    .clk(clk), .rst(rst), .acc_req(acc_req), .acc_adr(acc_adr), .acc_dat_o(acc_dat_o),
    .acc_ack(acc_ack), .mem_req(mem_req), .mem_adr(mem_adr), .mem_gnt(mem_gnt),
    .mem_dv(mem_dv), .mem_dat(mem_dat), .snoop_valid(snoop_valid), .snoop_adr(snoop_adr),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_di(buf_di), .buf_do(buf_do)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (buf_we[i]) ram[buf_addr][8*i+:8] <= buf_di[8*i+:8];
    buf_do <= ram[buf_addr];
  end
  always @(posedge clk) if (|buf_we) begin
    wr_cnt[buf_addr] <= wr_cnt[buf_addr] + 1;
    wr_tot <= wr_tot + 1;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  // snp: -2 snoop in request cycle, -1 none, 0..7 with that beat; abort: beat index that gets rst.
  task automatic do_read(input logic [31:0] a, input int maxgap, input int snp,
                         input logic [31:0] sadr, input int abort, input bit pat);
    logic [26:0] t;
    logic [31:0] d [8];
    int w, snap[8], g;
    bit hit;
    t = a[31:5];
    w = int'(a[4:2]);
    hit = mdl_valid && mdl_tag == t;
    for (int i = 0; i < 8; i++) d[i] = pat ? 32'hA0 + i : $urandom;
    acc_adr = a;
    acc_req = 1;
    if (snp == -2) begin snoop_valid = 1; snoop_adr = sadr; end
    @(negedge clk);
    snoop_valid = 0;
    if (hit) begin
      check("hit_ack", acc_ack, 1);
      check("hit_dat", acc_dat_o, mdl_data[w]);
      check("hit_noreq", mem_req, 0);
      if (SNP && snp == -2 && sadr[31:5] == mdl_tag) mdl_valid = 0;
    end else begin
      check("miss_req", mem_req, 1);
      check("miss_adr", mem_adr, {t, 5'b0});
      check("miss_noack", acc_ack, 0);
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        check("req_hold", mem_req, 1);
      end
      mem_gnt = 1;
      @(negedge clk);
      mem_gnt = 0;
      check("req_drop", mem_req, 0);
      foreach (snap[i]) snap[i] = wr_cnt[i];
      for (int b = 0; b < 8; b++) begin
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        mem_dv = 1;
        mem_dat = d[b];
        if (b == snp) begin snoop_valid = 1; snoop_adr = sadr; end
        if (b == abort) rst = 1;
        @(negedge clk);
        mem_dv = 0;
        snoop_valid = 0;
        if (b == abort) begin
          rst = 0;
          acc_req = 0;
          mdl_valid = 0;
          check("abort_noreq", mem_req, 0);
          repeat (4) begin
            check("abort_noack", acc_ack, 0);
            @(negedge clk);
          end
          return;
        end
      end
      check("read_noack", acc_ack, 0);
      @(negedge clk);
      check("miss_ack", acc_ack, 1);
      check("miss_dat", acc_dat_o, d[w]);
      for (int i = 0; i < 8; i++) check($sformatf("wr_addr%0d", i), wr_cnt[i] - snap[i], 1);
      mdl_tag = t;
      mdl_data = d;
      mdl_valid = !(SNP && snp >= 0 && snp < 8 && sadr[31:5] == t);
    end
    acc_req = 0;
    @(negedge clk);
    check("ack_pulse", acc_ack, 0);
  endtask
  initial begin
    int tot0;
    repeat (3) @(negedge clk);
    check("rst_ack", acc_ack, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", buf_we, 0);
    check("rst_madr", mem_adr, 0);
    check("rst_dat", acc_dat_o, 0);
    rst = 0;
    @(negedge clk);
    do_read(32'h100, 0, -1, 0, -1, 1);
    do_read(32'h11C, 0, -1, 0, -1, 0);
    do_read(32'h120, 3, -1, 0, -1, 0);
    do_read(32'h104, 3, -1, 0, -1, 0);
    do_read(32'h140, 3, 3, 32'h148, -1, 0);
    do_read(32'h144, 1, -1, 0, -1, 0);
    do_read(32'h14C, 1, -1, 0, -1, 0);
    do_read(32'h148, 1, -2, 32'h140, -1, 0);
    do_read(32'h150, 1, -1, 0, -1, 0);
    tot0 = wr_tot;
    mem_dv = 1;
    mem_dat = 32'hDEAD;
    @(negedge clk);
    mem_dv = 0;
    check("stray_dv", wr_tot - tot0, 0);
    for (int k = 0; k < 12; k++)
      do_read(32'h100 + 32'h20 * $urandom_range(0, 3) + 4 * $urandom_range(0, 7), 3,
              int'($urandom_range(0, 9)) - 2, 32'h100 + 32'h20 * $urandom_range(0, 3), -1, 0);
    do_read(32'h100, 0, -1, 0, -1, 1);
    do_read(32'h180, 2, -1, 0, 3, 0);
    do_read(32'h100, 0, -1, 0, -1, 0);
    do_read(32'h100, 0, -1, 0, -1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
